// File: rtl/light_uart_pkg.sv
// Shared constants and types for the LightUart receive path.
package light_uart_pkg;

  localparam int CHAR_WIDTH       = 8;
  localparam int OVERSAMPLE_SHIFT = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/light_uart_sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty flags and occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module light_uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      fill_q;
  logic             wr_ok, rd_ok;

  assign full_o    = (fill_q == (AW+1)'(DEPTH));
  assign empty_o   = (fill_q == '0);
  assign fill_o    = fill_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_ok);

  // Storage write; entries carry no reset since occupancy governs validity.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   fill_q <= fill_q + (AW+1)'(1);
        2'b01:   fill_q <= fill_q - (AW+1)'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: rtl/light_uart_rx_fifo.sv
// UART receiver (8N1+, LSB first, 16x oversampled bit timing) feeding a byte
// FIFO with valid/ready output and an rts hold-off line for the transmitter.
module light_uart_rx_fifo
  import light_uart_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int RTS_THRESHOLD = 12,
  parameter int DBR_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic [DBR_WIDTH-1:0]          dbr,
  output logic [CHAR_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          rts,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy
);

  localparam int CW = DBR_WIDTH + OVERSAMPLE_SHIFT;
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FW-1:0] RTS_TH = FW'(RTS_THRESHOLD);

  logic                  sync1_q, rxd_s_q;
  rx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         cpb_q, cpb_d;
  logic [2:0]            idx_q, idx_d;
  logic [CHAR_WIDTH-1:0] shift_q, shift_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  rts_q;
  logic                  push_req;
  logic                  pop;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         cpb_new;

  assign cpb_new = {dbr, {OVERSAMPLE_SHIFT{1'b0}}};
  assign pop     = m_valid && m_ready;

  // Two-flop synchronizer for the asynchronous serial line; resets to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxd_s_q <= sync1_q;
    end
  end

  // Receive FSM: half-bit wait to centre on the start bit, then one bit per cpb.
  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    cpb_d    = cpb_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxd_s_q && (dbr != '0)) begin
          cpb_d   = cpb_new;
          cnt_d   = (cpb_new >> 1) - CW'(1);
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rxd_s_q) begin
            cnt_d   = cpb_q - CW'(1);
            idx_d   = 3'd0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rxd_s_q;
          cnt_d          = cpb_q - CW'(1);
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (rxd_s_q) begin
            push_req = 1'b1;
            ovr_d    = fifo_full && !pop;
            state_d  = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxd_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM control registers and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cpb_q   <= '0;
      idx_q   <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cpb_q   <= cpb_d;
      idx_q   <= idx_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Assembled byte; only meaningful once a full frame has been shifted in.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // Registered flow control; held in hold-off while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset) rts_q <= 1'b1;
    else       rts_q <= (fill_level >= RTS_TH);
  end

  light_uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CHAR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (push_req),
    .wr_data_i (shift_q),
    .rd_en_i   (pop),
    .rd_data_o (m_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .fill_o    (fill_level)
  );

  assign m_valid   = !fifo_empty;
  assign rts       = rts_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_light_uart_rx_fifo.sv
// Directed testbench for light_uart_rx_fifo.
module tb_light_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        rxd;
  logic [15:0] dbr;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  fill_level;
  logic        rts;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  int          ferr_cnt = 0;
  int          ovr_cnt  = 0;
  logic [7:0]  popped[$];

  light_uart_rx_fifo #(
    .FIFO_DEPTH    (16),
    .RTS_THRESHOLD (12),
    .DBR_WIDTH     (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .dbr        (dbr),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fill_level (fill_level),
    .rts        (rts),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters and pop log, sampled with pre-edge values.
  always @(posedge clk) begin
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    if (m_valid && m_ready) popped.push_back(m_data);
  end

  // Drives one frame starting at a negedge; leaves rxd at the stop level.
  task automatic send_frame(input logic [7:0] b, input int cpb, input int nstop, input logic stop_v);
    rxd = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (cpb) @(negedge clk);
    end
    for (int i = 0; i < nstop; i++) begin
      rxd = stop_v;
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; rxd = 1'b1; dbr = 16'd0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({m_valid, fill_level, rts, frame_err, overrun, busy} !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_values: got valid=%b fill=%0d rts=%b ferr=%b ovr=%b busy=%b, want 0 0 1 0 0 0",
               m_valid, fill_level, rts, frame_err, overrun, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rts !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rts_release: got rts=%b, want 0", rts);
    end
  endtask

  task automatic test_dbr_zero;
    dbr = 16'd0;
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL dbr_zero_busy: got busy=%b, want 0", busy);
    end
    rxd = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic;
    int f0, o0;
    dbr = 16'd1; m_ready = 1'b1;
    f0 = ferr_cnt; o0 = ovr_cnt;
    fork
      send_frame(8'h55, 16, 3, 1'b1);
      begin
        // rxd falls before edge T; edges T..T+153 pass, push lands on edge T+154
        repeat (154) @(posedge clk);
        #1;
        tests_run++;
        if (m_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL basic_early_valid: got valid=%b, want 0", m_valid);
        end
        @(posedge clk); #1;
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 8'h55) begin
          tests_failed++;
          $display("FAIL basic_latency: got valid=%b data=%h, want 1 55", m_valid, m_data);
        end
        @(posedge clk); #1;
        tests_run++;
        if (m_valid !== 1'b0 || fill_level !== 5'd0) begin
          tests_failed++;
          $display("FAIL basic_drain: got valid=%b fill=%0d, want 0 0", m_valid, fill_level);
        end
      end
    join
    repeat (10) @(negedge clk);
    tests_run++;
    if (ferr_cnt != f0 || ovr_cnt != o0) begin
      tests_failed++;
      $display("FAIL basic_pulses: got ferr=%0d ovr=%0d, want 0 0", ferr_cnt - f0, ovr_cnt - o0);
    end
  endtask

  task automatic test_glitch;
    int f0;
    dbr = 16'd1; f0 = ferr_cnt;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL glitch_detect: got busy=%b, want 1", busy);
    end
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || fill_level !== 5'd0 || ferr_cnt != f0) begin
      tests_failed++;
      $display("FAIL glitch_reject: got busy=%b fill=%0d ferr=%0d, want 0 0 0", busy, fill_level, ferr_cnt - f0);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_frame_err;
    int f0, p0;
    dbr = 16'd2; m_ready = 1'b1;
    f0 = ferr_cnt; p0 = popped.size();
    send_frame(8'hA3, 32, 1, 1'b0);
    repeat (100) @(negedge clk);
    tests_run++;
    if (ferr_cnt - f0 != 1 || fill_level !== 5'd0 || popped.size() != p0) begin
      tests_failed++;
      $display("FAIL frame_err_pulse: got ferr=%0d fill=%0d pops=%0d, want 1 0 0",
               ferr_cnt - f0, fill_level, popped.size() - p0);
    end
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL frame_err_wait_idle: got busy=%b, want 1", busy);
    end
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_err_recover: got busy=%b, want 0", busy);
    end
    send_frame(8'h3C, 32, 1, 1'b1);
    repeat (40) @(negedge clk);
    tests_run++;
    if (popped.size() != p0 + 1 || popped[popped.size()-1] !== 8'h3C || ferr_cnt - f0 != 1) begin
      tests_failed++;
      $display("FAIL frame_err_next_byte: got pops=%0d last=%h ferr=%0d, want 1 3c 1",
               popped.size() - p0, (popped.size() > 0) ? popped[popped.size()-1] : 8'hxx, ferr_cnt - f0);
    end
  endtask

  task automatic test_overrun;
    int o0, f0;
    dbr = 16'd1; m_ready = 1'b0;
    o0 = ovr_cnt; f0 = ferr_cnt;
    for (int i = 0; i < 11; i++) send_frame(i[7:0], 16, 3, 1'b1);
    tests_run++;
    if (fill_level !== 5'd11 || rts !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovr_fill11: got fill=%0d rts=%b, want 11 0", fill_level, rts);
    end
    fork
      send_frame(8'd11, 16, 3, 1'b1);
      begin
        int n;
        n = 0;
        while (fill_level != 5'd12 && n < 200) begin
          @(negedge clk);
          n++;
        end
        tests_run++;
        if (n >= 200 || rts !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovr_rts_at_12: got fill=%0d rts=%b waited=%0d, want 12 0 <200", fill_level, rts, n);
        end
        @(negedge clk);
        tests_run++;
        if (rts !== 1'b1) begin
          tests_failed++;
          $display("FAIL ovr_rts_after_12: got rts=%b, want 1", rts);
        end
      end
    join
    for (int i = 12; i < 17; i++) send_frame(i[7:0], 16, 3, 1'b1);
    tests_run++;
    if (fill_level !== 5'd16 || ovr_cnt - o0 != 1 || ferr_cnt != f0 || m_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL ovr_full: got fill=%0d ovr=%0d ferr=%0d head=%h, want 16 1 0 00",
               fill_level, ovr_cnt - o0, ferr_cnt - f0, m_data);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (m_valid !== 1'b1 || m_data !== k[7:0]) begin
        tests_failed++;
        $display("FAIL ovr_drain_%0d: got valid=%b data=%h, want 1 %h", k, m_valid, m_data, k[7:0]);
      end
      if (k == 5) begin
        tests_run++;
        if (fill_level !== 5'd11 || rts !== 1'b1) begin
          tests_failed++;
          $display("FAIL ovr_rts_at_11: got fill=%0d rts=%b, want 11 1", fill_level, rts);
        end
      end
      if (k == 6) begin
        tests_run++;
        if (rts !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovr_rts_release: got rts=%b, want 0", rts);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (m_valid !== 1'b0 || fill_level !== 5'd0) begin
      tests_failed++;
      $display("FAIL ovr_empty: got valid=%b fill=%0d, want 0 0", m_valid, fill_level);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_midframe;
    int f0, o0, p0;
    logic [7:0] partial;
    partial = 8'h5A;
    dbr = 16'd1; m_ready = 1'b0;
    send_frame(8'h11, 16, 3, 1'b1);
    tests_run++;
    if (fill_level !== 5'd1) begin
      tests_failed++;
      $display("FAIL midrst_prefill: got fill=%0d, want 1", fill_level);
    end
    f0 = ferr_cnt; o0 = ovr_cnt;
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = partial[i];
      repeat (16) @(negedge clk);
    end
    rxd = partial[4];
    repeat (8) @(negedge clk);
    reset = 1'b1; rxd = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({m_valid, fill_level, rts, frame_err, overrun, busy} !== {1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midrst_values: got valid=%b fill=%0d rts=%b ferr=%b ovr=%b busy=%b, want 0 0 1 0 0 0",
               m_valid, fill_level, rts, frame_err, overrun, busy);
    end
    reset = 1'b0;
    repeat (300) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || fill_level !== 5'd0 || rts !== 1'b0 || ferr_cnt != f0 || ovr_cnt != o0) begin
      tests_failed++;
      $display("FAIL midrst_quiet: got busy=%b fill=%0d rts=%b ferr=%0d ovr=%0d, want 0 0 0 0 0",
               busy, fill_level, rts, ferr_cnt - f0, ovr_cnt - o0);
    end
    m_ready = 1'b1;
    p0 = popped.size();
    send_frame(8'h7E, 16, 3, 1'b1);
    repeat (10) @(negedge clk);
    tests_run++;
    if (popped.size() != p0 + 1 || popped[popped.size()-1] !== 8'h7E) begin
      tests_failed++;
      $display("FAIL midrst_next_byte: got pops=%0d last=%h, want 1 7e",
               popped.size() - p0, (popped.size() > 0) ? popped[popped.size()-1] : 8'hxx);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int f0, o0, p0;
    logic [7:0] exp_b [3];
    bit toggle_en;
    exp_b[0] = 8'h01; exp_b[1] = 8'hFF; exp_b[2] = 8'h80;
    dbr = 16'd1;
    f0 = ferr_cnt; o0 = ovr_cnt; p0 = popped.size();
    toggle_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 16, 1, 1'b1);
        repeat (60) @(negedge clk);
        toggle_en = 1'b0;
      end
      begin
        while (toggle_en) begin
          @(posedge clk);
          #2 m_ready = ~m_ready;
        end
      end
    join
    m_ready = 1'b0;
    tests_run++;
    if (popped.size() != p0 + 3 || ferr_cnt != f0 || ovr_cnt != o0) begin
      tests_failed++;
      $display("FAIL b2b_count: got pops=%0d ferr=%0d ovr=%0d, want 3 0 0",
               popped.size() - p0, ferr_cnt - f0, ovr_cnt - o0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (popped[p0+i] !== exp_b[i]) begin
          tests_failed++;
          $display("FAIL b2b_byte_%0d: got %h, want %h", i, popped[p0+i], exp_b[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; rxd = 1'b1; dbr = 16'd0; m_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_dbr_zero();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/light_uart_rx_fifo.md
Name: light_uart_rx_fifo

Overview:
- Synthesizable DUT-side UART receiver plus elastic buffer; sits directly downstream of the LightUart transactor's txd line.
- Deserializes frames: 1 start bit, 8 data bits LSB-first, 1 or more stop bits. The transactor sends 3 stop bits.
- Uses the same bit timing as the transactor: clocks-per-bit = dbr<<4.
- Buffers bytes in a FIFO with a valid/ready output. Drives an rts flow-control line back to the transactor's cts.

Parameters:
- FIFO_DEPTH, 16, byte entries; power of two, minimum 2.
- RTS_THRESHOLD, 12, fill level at which rts deasserts the "ready" condition (goes to 1).
- DBR_WIDTH, 16, width of the dbr divisor input.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rxd  in  1  serial input, asynchronous to clk; idle level 1.
- dbr  in  DBR_WIDTH  baud divisor; clocks-per-bit = dbr<<4; 0 disables reception.
- m_data  out  8  head-of-FIFO byte.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts; pop when m_valid && m_ready.
- fill_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- rts  out  1  active-low send permission to transactor cts: 0 = may send, 1 = hold off.
- frame_err  out  1  one-cycle pulse, stop bit sampled 0.
- overrun  out  1  one-cycle pulse, good byte dropped because FIFO was full.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: m_valid=0, fill_level=0, rts=1, frame_err=0, overrun=0, busy=0. Pointers are cleared and the FSM goes to IDLE.
- Reset mid-frame abandons the partial byte, empties the FIFO, and emits no pulses.
- Synchronizer: 2 flops; the result is rxd_s, with 2 cycles of latency. All sampling uses rxd_s.
- Timing:
  - cpb = dbr<<4, sized DBR_WIDTH+4.
  - half = cpb>>1.
  - cpb and half are latched at start detect; dbr changes mid-frame are ignored.
- Down-counter cnt: a load of N produces an event N+1 cycles later, at cnt==0.
- FSM:
  - IDLE: if rxd_s==0 and dbr!=0, load cnt=half-1 and go to START.
  - START: at cnt==0, if rxd_s==0, load cnt=cpb-1, clear bit index, go to DATA. If rxd_s==1 (glitch), go to IDLE and do not push.
  - DATA: at cnt==0, shift rxd_s into bit[idx]. After idx 7, load cnt=cpb-1 and go to STOP; otherwise reload cpb-1.
  - STOP: at cnt==0:
    - rxd_s==1: push the byte if not full, else pulse overrun; go to IDLE.
    - rxd_s==0: pulse frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: hold until rxd_s==1, then go to IDLE. This handles break conditions.
- End-to-end latency: the rxd falling edge at cycle T gives a stop-bit sample at T+154 when dbr=1. The push happens in that cycle; m_valid=1 at T+155.
- The next start bit is accepted as early as the cycle after STOP, so a single stop bit is supported.
- FIFO:
  - Show-ahead: m_data = mem[rd_ptr], valid whenever m_valid=1.
  - Push and pop in the same cycle leave fill unchanged.
  - When full with a simultaneous pop, the push is accepted (no overrun).
  - Pop when empty is impossible because m_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- rts is registered: 1 when fill_level >= RTS_THRESHOLD, else 0. It deasserts (returns to 0) the cycle after fill drops below threshold. After reset it is 0 from the first post-reset cycle.

Decomposition:
- Package light_uart_pkg:
  - CHAR_WIDTH=8.
  - OVERSAMPLE_SHIFT=4.
  - rx state enum {IDLE, START, DATA, STOP, WAIT_IDLE}.
- Sub-module light_uart_sync_fifo: parameterised depth/width, show-ahead, with full/empty/fill.
- Top level holds the synchronizer, the FSM, the counters, and rts/pulse logic.

Test Plan:
- dbr=1, send 0x55 with 3 stop bits, m_ready=1 → m_data=0x55, m_valid=1 exactly 155 cycles after the rxd falling edge, held 1 cycle, fill returns to 0.
- dbr=1, rxd low for 4 cycles then high → no push, no frame_err, FSM back to IDLE within 12 cycles.
- dbr=2, send 0xA3 with stop bit forced 0, rxd held low 100 cycles → frame_err single pulse, fill stays 0. A subsequent 0x3C frame is received correctly only after rxd returns high.
- dbr=1, m_ready=0, send 17 bytes 0x00..0x10 → fill_level=16. rts=1 from the cycle after the 12th push. overrun pulses once on the 17th. Draining yields 0x00..0x0F in order; rts returns to 0 when fill hits 11.
- dbr=1, assert reset for 1 cycle midway through data bit 4 of a frame → no push, no pulses, outputs at reset values. The next full frame 0x7E is received correctly.
- dbr=1, back-to-back frames with 1 stop bit (0x01, 0xFF, 0x80), m_ready toggling every cycle → all three bytes delivered in order, no errors.
